// File: rtl/cl_stream_xform_if.sv
// Read-FIFO / write-FIFO handshake bundle for the cache-line transform stage.
// master is the transform side; slave is the FIFO side.
interface cl_stream_xform_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_rd_en;
  logic                  out_full;
  logic                  out_wr_en;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  in_empty,
    input  in_data,
    output in_rd_en,
    input  out_full,
    output out_wr_en,
    output out_data
  );

  modport slave (
    output in_empty,
    output in_data,
    input  in_rd_en,
    output out_full,
    input  out_wr_en,
    input  out_data
  );
endinterface

// File: rtl/cl_stream_xform.sv
// Streaming cache-line transform: adds a per-job addend to every lane of each line
// moving from the DMA read FIFO to the DMA write FIFO, through a two-stage pipeline.
module cl_stream_xform #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned LANE_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [LANE_WIDTH-1:0] addend,
  cl_stream_xform_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] lines_out
);

  localparam int unsigned NumLanes = DATA_WIDTH / LANE_WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [LANE_WIDTH-1:0] addend_q, addend_d;
  logic [SIZE_WIDTH-1:0] rd_count_q, rd_count_d;
  logic [SIZE_WIDTH-1:0] lines_out_q, lines_out_d;
  logic                  done_q, done_d;

  logic                  s1_valid_q, s2_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
  logic [DATA_WIDTH-1:0] sum;

  logic go_accept;
  logic stall;
  logic s1_load;
  logic pop;
  logic push;
  logic last_push;

  // Pipeline control
  always_comb begin
    stall   = s2_valid_q && bus.out_full;
    s1_load = !(s1_valid_q && stall);
    pop     = (state_q == StRun) && !bus.in_empty && (rd_count_q < size_q) && s1_load;
    push    = s2_valid_q && !bus.out_full;
  end

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.out_data  = s2_data_q;

  // Lane-wise add; each lane wraps independently, no carry between lanes.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      sum[i*LANE_WIDTH +: LANE_WIDTH] = s1_data_q[i*LANE_WIDTH +: LANE_WIDTH] + addend_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= pop;
        if (pop) begin
          s1_data_q <= bus.in_data;
        end
      end
      if (!stall) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= sum;
        end
      end
    end
  end

  // Job control: go is honoured only outside RUN.
  always_comb begin
    go_accept = go && (state_q != StRun);
    last_push = push && ((lines_out_q + SIZE_WIDTH'(1)) == size_q);

    state_d     = state_q;
    size_d      = size_q;
    addend_d    = addend_q;
    rd_count_d  = rd_count_q;
    lines_out_d = lines_out_q;
    done_d      = done_q;

    case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d = (size == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_push) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_accept) begin
      size_d      = size;
      addend_d    = addend;
      rd_count_d  = '0;
      lines_out_d = '0;
      done_d      = (size == '0);
    end else begin
      if (pop) begin
        rd_count_d = rd_count_q + SIZE_WIDTH'(1);
      end
      if (push && (lines_out_q < size_q)) begin
        lines_out_d = lines_out_q + SIZE_WIDTH'(1);
      end
      if ((state_q == StRun) && last_push) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      size_q      <= '0;
      addend_q    <= '0;
      rd_count_q  <= '0;
      lines_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      addend_q    <= addend_d;
      rd_count_q  <= rd_count_d;
      lines_out_q <= lines_out_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign lines_out = lines_out_q;

endmodule

// File: tb/tb_cl_stream_xform.sv
// Directed bench for cl_stream_xform: a queue models the read FIFO, pushes are
// logged with their cycle numbers and compared against hand-computed lines.
module tb_cl_stream_xform;

  logic        clk;
  logic        rst;
  logic        go;
  logic [16:0] size;
  logic [31:0] addend;
  logic        busy;
  logic        done;
  logic [16:0] lines_out;

  cl_stream_xform_if #(.DATA_WIDTH(512)) bus ();

  cl_stream_xform #(
    .DATA_WIDTH(512),
    .LANE_WIDTH(32),
    .SIZE_WIDTH(17)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .size     (size),
    .addend   (addend),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .lines_out(lines_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [511:0] fifo[$];
  logic [511:0] outq[$];
  int           pop_cyc[$];
  int           push_cyc[$];
  int           cyc        = 0;
  int           pops       = 0;
  int           viol       = 0;
  int           stall_seen = 0;
  int           full_from  = 0;
  int           full_to    = 0;
  int           done_cyc   = -1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input logic [31:0] v);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = v;
    return l;
  endfunction

  task automatic drive_fifo();
    bus.in_empty = (fifo.size() == 0);
    bus.in_data  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic clear_log();
    outq.delete();
    pop_cyc.delete();
    push_cyc.delete();
    pops       = 0;
    viol       = 0;
    stall_seen = 0;
    done_cyc   = -1;
  endtask

  // One clock: sample handshakes mid-cycle, then retire the pop after the edge.
  task automatic cycle();
    logic do_pop, do_push;
    @(negedge clk);
    do_pop  = bus.in_rd_en;
    do_push = bus.out_wr_en;
    if (do_pop && bus.in_empty) viol++;
    if (do_push && bus.out_full) viol++;
    if (bus.out_full && !do_pop && fifo.size() != 0) stall_seen = 1;
    if (do_push) begin
      outq.push_back(bus.out_data);
      push_cyc.push_back(cyc);
    end
    if (do_pop) begin
      pops++;
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (do_pop && fifo.size() != 0) fifo.delete(0);
    drive_fifo();
    bus.out_full = (cyc >= full_from) && (cyc < full_to);
  endtask

  task automatic start(input logic [16:0] s, input logic [31:0] a);
    go     = 1'b1;
    size   = s;
    addend = a;
    cycle();
    go     = 1'b0;
  endtask

  task automatic run_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done) begin
        done_cyc = cyc;
        return;
      end
    end
    chk("done_timeout", 512'd0, 512'd1);
  endtask

  logic [511:0] line;
  logic [511:0] exp;

  initial begin
    rst          = 1'b0;
    go           = 1'b0;
    size         = '0;
    addend       = '0;
    bus.out_full = 1'b0;
    drive_fifo();
    #1;
    chk("rst_rd_en", 512'(bus.in_rd_en), 512'd0);
    chk("rst_wr_en", 512'(bus.out_wr_en), 512'd0);
    chk("rst_data", bus.out_data, 512'd0);
    chk("rst_busy_done_lines", 512'({busy, done, lines_out}), 512'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic: four lines of 0x10, addend 1
    clear_log();
    for (int i = 0; i < 4; i++) fifo.push_back(mkline(32'h10));
    drive_fifo();
    start(17'd4, 32'd1);
    chk("basic_busy", 512'(busy), 512'd1);
    run_done(30);
    chk("basic_npush", 512'(outq.size()), 512'd4);
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      chk("basic_data", outq[i], mkline(32'h11));
      chk("basic_latency", 512'(push_cyc[i] - pop_cyc[i]), 512'd2);
    end
    if (push_cyc.size() == 4) chk("basic_done_cyc", 512'(done_cyc), 512'(push_cyc[3] + 1));
    chk("basic_lines_out", 512'(lines_out), 512'd4);
    chk("basic_busy_end", 512'(busy), 512'd0);

    // Lane wrap: lane0 wraps without carrying into lane1
    clear_log();
    line = mkline(32'h0);
    line[31:0]    = 32'hFFFF_FFFF;
    line[63:32]   = 32'h0000_0005;
    line[511:480] = 32'h7FFF_FFFF;
    fifo.push_back(line);
    drive_fifo();
    start(17'd1, 32'd1);
    run_done(20);
    exp = mkline(32'h1);
    exp[31:0]    = 32'h0000_0000;
    exp[63:32]   = 32'h0000_0006;
    exp[511:480] = 32'h8000_0000;
    chk("wrap_npush", 512'(outq.size()), 512'd1);
    if (outq.size() != 0) chk("wrap_data", outq[0], exp);

    // Backpressure: out_full high for 5 cycles mid-stream
    clear_log();
    for (int i = 0; i < 8; i++) fifo.push_back(mkline(32'hA0 + 32'(i)));
    drive_fifo();
    full_from = cyc + 4;
    full_to   = cyc + 9;
    start(17'd8, 32'h100);
    run_done(60);
    full_from = 0;
    full_to   = 0;
    chk("bp_npush", 512'(outq.size()), 512'd8);
    for (int i = 0; i < 8 && i < outq.size(); i++) chk("bp_data", outq[i], mkline(32'h1A0 + 32'(i)));
    chk("bp_pops", 512'(pops), 512'd8);
    chk("bp_stall_seen", 512'(stall_seen), 512'd1);
    chk("bp_viol", 512'(viol), 512'd0);
    chk("bp_lines_out", 512'(lines_out), 512'd8);

    // Over-read: size 3 with 6 lines available
    clear_log();
    for (int i = 0; i < 6; i++) fifo.push_back(mkline(32'h200 + 32'(i)));
    drive_fifo();
    start(17'd3, 32'h5);
    run_done(30);
    repeat (3) cycle();
    chk("over_pops", 512'(pops), 512'd3);
    chk("over_npush", 512'(outq.size()), 512'd3);
    chk("over_fifo_left", 512'(fifo.size()), 512'd3);
    if (outq.size() == 3) chk("over_last", outq[2], mkline(32'h207));

    // Zero-size job with lines still waiting in the FIFO
    clear_log();
    start(17'd0, 32'h9);
    chk("zero_done", 512'(done), 512'd1);
    chk("zero_busy", 512'(busy), 512'd0);
    repeat (4) cycle();
    chk("zero_pops", 512'(pops), 512'd0);
    chk("zero_lines_out", 512'(lines_out), 512'd0);
    fifo.delete();
    drive_fifo();

    // go while busy is ignored; go from DONE restarts
    clear_log();
    for (int i = 0; i < 9; i++) fifo.push_back(mkline(32'h300 + 32'(i)));
    drive_fifo();
    start(17'd5, 32'h10);
    repeat (2) cycle();
    start(17'd9, 32'h55);
    run_done(40);
    repeat (2) cycle();
    chk("busygo_npush", 512'(outq.size()), 512'd5);
    chk("busygo_pops", 512'(pops), 512'd5);
    chk("busygo_lines_out", 512'(lines_out), 512'd5);
    if (outq.size() == 5) chk("busygo_last", outq[4], mkline(32'h314));
    clear_log();
    start(17'd2, 32'h1000);
    chk("restart_done_clr", 512'(done), 512'd0);
    chk("restart_lines_clr", 512'(lines_out), 512'd0);
    chk("restart_busy", 512'(busy), 512'd1);
    run_done(30);
    chk("restart_npush", 512'(outq.size()), 512'd2);
    if (outq.size() == 2) chk("restart_data", outq[1], mkline(32'h1306));
    fifo.delete();
    drive_fifo();

    // Reset after two of five lines pushed
    clear_log();
    for (int i = 0; i < 5; i++) fifo.push_back(mkline(32'h400 + 32'(i)));
    drive_fifo();
    start(17'd5, 32'h1);
    for (int i = 0; i < 30 && outq.size() < 2; i++) cycle();
    chk("rstmid_pushed2", 512'(outq.size()), 512'd2);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_wr_en", 512'(bus.out_wr_en), 512'd0);
    chk("rstmid_rd_en", 512'(bus.in_rd_en), 512'd0);
    chk("rstmid_data", bus.out_data, 512'd0);
    chk("rstmid_state", 512'({busy, done, lines_out}), 512'd0);
    cycle();
    rst = 1'b1;
    clear_log();
    repeat (10) cycle();
    chk("rstmid_no_push", 512'(outq.size()), 512'd0);
    chk("rstmid_no_pop", 512'(pops), 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cl_stream_xform.md
Name: cl_stream_xform

Overview:
- Streaming cache-line transform stage between the DMA read FIFO and the DMA write FIFO in the copy AFU; it replaces the direct rd_data-to-wr_data connection.
- Each 512-bit line popped from the read side has a 32-bit addend added to every 32-bit lane, modulo 2^32 per lane, and is pushed to the write side.
- Two-stage registered pipeline with full backpressure.
- Counts lines against the job size and raises done when the last transformed line has been written.

Parameters:
DATA_WIDTH, 512, cache-line width in bits; integer multiple of LANE_WIDTH
LANE_WIDTH, 32, lane width in bits for the per-lane add
SIZE_WIDTH, 17, width of size and line counters (DMA ADDR_WIDTH+1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
go  in  1  single-cycle job start pulse
size  in  SIZE_WIDTH  job length in cache lines; sampled when go is accepted
addend  in  LANE_WIDTH  per-lane addend; sampled when go is accepted
in_empty  in  1  read FIFO empty
in_data  in  DATA_WIDTH  read FIFO head data (show-ahead; valid whenever !in_empty)
in_rd_en  out  1  pop read FIFO this cycle
out_full  in  1  write FIFO full
out_wr_en  out  1  push out_data this cycle
out_data  out  DATA_WIDTH  transformed line
busy  out  1  job in progress
done  out  1  job complete; held until next accepted go
lines_out  out  SIZE_WIDTH  lines written in current/last job

Behaviour:
- Reset values: in_rd_en=0, out_wr_en=0, out_data=0, busy=0, done=0, lines_out=0; FSM=IDLE; both pipeline valids=0; counters=0.
- FSM has three states: IDLE, RUN, DONE.
- go accepted in IDLE or DONE:
  - latch size and addend; clear rd_count, lines_out and done.
  - next state is RUN, or DONE directly if size==0 (done=1 the following cycle, no FIFO activity).
- go while in RUN is ignored; latched size and addend are unchanged.
- Transitions:
  - RUN -> DONE on the cycle a push makes lines_out reach size; done=1 and busy=0 from the next cycle.
  - DONE -> RUN only on go.
  - busy = (state==RUN).
- Pipeline:
  - s1 registers the raw popped line; s2 registers the lane-wise sum.
  - stall = s2_valid && out_full.
  - s2 loads from s1 when !stall.
  - s1 loads from input when !(s1_valid && stall).
- in_rd_en = RUN && !in_empty && (rd_count < size) && !(s1_valid && stall). Combinational; never asserted when in_empty=1.
- out_wr_en = s2_valid && !out_full. Combinational; never asserted when out_full=1. out_data = s2 data.
- Latency: a line popped at cycle t is pushed at t+2 at the earliest.
- Throughput: one line/cycle with no backpressure.
- Arithmetic:
  - lane i of out = in lane i + addend, truncated to LANE_WIDTH.
  - No carry between lanes; lane 0 occupies bits [LANE_WIDTH-1:0].
- rd_count increments on each pop and never exceeds size: no over-read even if the FIFO holds extra lines.
- lines_out increments on each push and saturates at size.
- Simultaneous pop and push in one cycle are both counted.
- Backpressure: while out_full=1, no data is lost or duplicated; at most two lines are held internally.
- Reset mid-operation: all state cleared immediately, including in-flight pipeline data; outputs return to reset values.

Test Plan:
- Basic: size=4, addend=1, lines with all lanes=0x10 presented back-to-back, out_full=0 -> four pushes of all lanes=0x11 at pop cycle+2; done=1 and lines_out=4 one cycle after 4th push.
- Lane wrap: addend=1, line with lane0=0xFFFFFFFF, lane1=0x00000005 -> lane0=0x00000000, lane1=0x00000006 (no carry into lane1).
- Backpressure: size=8, out_full high 5 cycles mid-stream -> in_rd_en drops once the pipeline is full; exactly 8 pushes in order; no push while out_full=1.
- Zero/over-read: size=0 -> done=1 next cycle, in_rd_en never high. size=3 with 6 lines in FIFO -> exactly 3 pops.
- go while busy: second go mid-job with size=9 -> ignored; job ends at the original size; new go from DONE clears done and restarts.
- Reset mid-run: rst low after 2 of 5 lines pushed -> outputs zero asynchronously; after release, no pushes until a new go.
